// File: rtl/lcd_fb_pkg.sv
// Shared definitions for the LCD framebuffer scanner: default geometry,
// derived byte counts and the scanner FSM state type.
package lcd_fb_pkg;

   // Default framebuffer geometry (FB_W * FB_H must equal 2**ADDR_W)
   localparam int unsigned FB_W_DEF      = 128;
   localparam int unsigned FB_H_DEF      = 128;
   localparam int unsigned ADDR_W_DEF    = 14;

   // Pixels packed per output byte and bytes per framebuffer row
   localparam int unsigned PIX_PER_BYTE  = 8;
   localparam int unsigned BYTES_PER_ROW = FB_W_DEF / PIX_PER_BYTE;

   // Scanner FSM states
   typedef enum logic [2:0] {
      StIdle,
      StRead,
      StDrain,
      StOut,
      StDone
   } state_e;

endpackage

// File: rtl/lcd_fb_packer.sv
// 8-bit MSB-first pixel packer: the first bit shifted in ends up in bit 7.
// o_last flags the shift that completes a byte; o_full stays high from then
// until the byte is consumed (i_clr).
module lcd_fb_packer (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_shift,
   input  logic       i_bit,
   input  logic       i_clr,
   output logic [7:0] o_data,
   output logic       o_full,
   output logic       o_last
);

   logic [7:0] r_sr;
   logic [2:0] r_cnt;
   logic       r_full;

   // Eighth bit of a byte is being shifted in this cycle
   always_comb begin
      o_last = i_shift && (r_cnt == 3'd7);
   end

   // Shift register, bit counter and full flag
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_sr   <= 8'h00;
         r_cnt  <= 3'd0;
         r_full <= 1'b0;
      end else begin
         if (i_shift) begin
            r_sr  <= {r_sr[6:0], i_bit};
            r_cnt <= r_cnt + 3'd1;
         end
         if (o_last) begin
            r_full <= 1'b1;
         end else if (i_clr) begin
            r_full <= 1'b0;
         end
      end
   end

   assign o_data = r_sr;
   assign o_full = r_full;

endmodule

// File: rtl/lcd_fb_scanner.sv
// LCD framebuffer scanner: reads a 1-bpp framebuffer eight pixels at a time,
// packs them MSB-first and hands each byte to a downstream serializer with a
// valid/ready handshake. One frame per start pulse.
// Build option: define LCD_SCAN_CONTINUOUS_EN to rescan frames back-to-back
// without a new start (done still pulses once per frame).
module lcd_fb_scanner
   import lcd_fb_pkg::*;
#(
   parameter int unsigned FB_W   = FB_W_DEF,
   parameter int unsigned FB_H   = FB_H_DEF,
   parameter int unsigned ADDR_W = ADDR_W_DEF
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_start,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_rd_en,
   output logic [ADDR_W-1:0] o_rd_addr,
   input  logic              i_rd_data,
   output logic [7:0]        o_byte_data,
   output logic              o_byte_valid,
   input  logic              i_byte_ready,
   output logic              o_row_first,
   output logic [6:0]        o_row_idx
);

   localparam int unsigned COL_W = $clog2(FB_W);
   // Base address of the final byte of a frame
   localparam logic [ADDR_W-1:0] LAST_BASE = ADDR_W'(FB_W * FB_H - PIX_PER_BYTE);
   localparam logic [ADDR_W-1:0] BYTE_STEP = ADDR_W'(PIX_PER_BYTE);

   state_e              r_state;
   state_e              w_state_d;
   logic [2:0]          r_rd_cnt;
   logic [ADDR_W-1:0]   r_rd_addr;
   logic [ADDR_W-1:0]   r_base;
   logic [ADDR_W-1:0]   w_base_d;
   logic                r_shift;
   logic                w_accept;
   logic                w_last_byte;
   logic                w_full;
   logic                w_last_bit;
   logic [7:0]          w_pack_data;

   lcd_fb_packer u_packer (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_shift (r_shift),
      .i_bit   (i_rd_data),
      .i_clr   (w_accept),
      .o_data  (w_pack_data),
      .o_full  (w_full),
      .o_last  (w_last_bit)
   );

   // Handshake, end-of-frame detect and next byte base
   always_comb begin
      w_accept    = o_byte_valid && i_byte_ready;
      w_last_byte = (r_base == LAST_BASE);
      // Wraps to 0 after the last byte because the frame fills the address space
      w_base_d    = w_accept ? (r_base + BYTE_STEP) : r_base;
   end

   // FSM next-state logic
   always_comb begin
      w_state_d = r_state;
      unique case (r_state)
         StIdle: begin
            if (i_start) begin
               w_state_d = StRead;
            end
         end
         StRead: begin
            if (r_rd_cnt == 3'd7) begin
               w_state_d = StDrain;
            end
         end
         StDrain: begin
            // Last pixel arrives one cycle after the last read
            if (w_last_bit) begin
               w_state_d = StOut;
            end
         end
         StOut: begin
            if (w_accept) begin
               w_state_d = w_last_byte ? StDone : StRead;
            end
         end
         StDone: begin
`ifdef LCD_SCAN_CONTINUOUS_EN
            w_state_d = StRead;
`else
            w_state_d = StIdle;
`endif
         end
         default: begin
            w_state_d = StIdle;
         end
      endcase
   end

   // State, read counter, read address, byte base and read-data pipeline flag
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state   <= StIdle;
         r_rd_cnt  <= 3'd0;
         r_rd_addr <= '0;
         r_base    <= '0;
         r_shift   <= 1'b0;
      end else begin
         r_state <= w_state_d;
         r_base  <= w_base_d;
         // rd_data is valid one cycle after rd_en
         r_shift <= (r_state == StRead);
         if (r_state == StRead) begin
            r_rd_cnt <= r_rd_cnt + 3'd1;
         end else begin
            r_rd_cnt <= 3'd0;
         end
         if ((w_state_d == StRead) && (r_state != StRead)) begin
            r_rd_addr <= w_base_d;
         end else if ((w_state_d == StRead) && (r_state == StRead)) begin
            r_rd_addr <= r_rd_addr + ADDR_W'(1);
         end
      end
   end

   // Output decode; row info is only meaningful alongside byte_valid
   always_comb begin
      o_busy       = (r_state != StIdle);
      o_done       = (r_state == StDone);
      o_rd_en      = (r_state == StRead);
      o_rd_addr    = r_rd_addr;
      o_byte_data  = w_pack_data;
      o_byte_valid = (r_state == StOut) && w_full;
      o_row_first  = o_byte_valid && (r_base[COL_W-1:0] == '0);
      o_row_idx    = o_byte_valid ? 7'(r_base[ADDR_W-1:COL_W]) : 7'd0;
   end

endmodule

// File: tb/tb_lcd_fb_scanner.sv
// Directed bench for lcd_fb_scanner with a registered 1-bpp framebuffer model.
module tb_lcd_fb_scanner;

   localparam int NPIX  = 16384;
   localparam int NBYTE = 2048;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        busy, done, rd_en, byte_valid, row_first;
   logic [13:0] rd_addr;
   logic        rd_data = 1'b0;
   logic [7:0]  byte_data;
   logic        byte_ready = 1'b1;
   logic [6:0]  row_idx;

   logic        mem [0:NPIX-1];
   logic [7:0]  rec_data [0:NBYTE-1];
   logic        rec_rf [0:NBYTE-1];
   logic [6:0]  rec_ri [0:NBYTE-1];

   int n_total = 0;
   int n_bad   = 0;
   // results of the most recent scan_frame
   int fv, dc, fa, nacc, nstall, nstall_err, ndone, prd, padr, pbusy;

   lcd_fb_scanner #(
      .FB_W   (128),
      .FB_H   (128),
      .ADDR_W (14)
   ) dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_start      (start),
      .o_busy       (busy),
      .o_done       (done),
      .o_rd_en      (rd_en),
      .o_rd_addr    (rd_addr),
      .i_rd_data    (rd_data),
      .o_byte_data  (byte_data),
      .o_byte_valid (byte_valid),
      .i_byte_ready (byte_ready),
      .o_row_first  (row_first),
      .o_row_idx    (row_idx)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (rd_en) rd_data <= mem[rd_addr];
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] exp_byte(input int i);
      logic [7:0] v;
      for (int b = 0; b < 8; b++) v[7-b] = mem[8*i+b];
      return v;
   endfunction

   task automatic do_reset();
      @(negedge clk); rst = 1'b1; start = 1'b0; byte_ready = 1'b1;
      @(negedge clk); @(negedge clk); rst = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_rd_en"}, rd_en, 0);
      chk({tag, "_rd_addr"}, rd_addr, 0);
      chk({tag, "_byte_data"}, byte_data, 0);
      chk({tag, "_byte_valid"}, byte_valid, 0);
      chk({tag, "_row_first"}, row_first, 0);
      chk({tag, "_row_idx"}, row_idx, 0);
   endtask

   // Compare every recorded byte against the framebuffer contents
   task automatic model_check(input string tag);
      int e = 0;
      for (int i = 0; i < NBYTE; i++) begin
         if (rec_data[i] !== exp_byte(i) || rec_rf[i] !== ((i % 16) == 0) ||
             rec_ri[i] !== 7'(i / 16)) e++;
      end
      chk(tag, e, 0);
   endtask

   // One frame from a start pulse; cycle n is sampled on the negedge before edge n
   task automatic scan_frame(input int stall_byte, input int stall_len, input bit repulse);
      int n = 0;
      int idx = 0;
      logic [7:0] held = 8'h00;
      for (int i = 0; i < NBYTE; i++) begin
         rec_data[i] = 8'hxx; rec_rf[i] = 1'bx; rec_ri[i] = 7'hxx;
      end
      fv = -1; dc = -1; fa = -1; nstall = 0; nstall_err = 0; ndone = 0;
      @(negedge clk); start = 1'b1; byte_ready = 1'b1;
      @(posedge clk);
      while (dc < 0 && n < 30000) begin
         @(negedge clk); n++;
         if (n == 1) begin start = 1'b0; fa = rd_addr; end
         if (repulse && n == 100) start = 1'b1;
         if (n == 101) start = 1'b0;
         byte_ready = 1'b1;
         if (byte_valid) begin
            if (fv < 0) fv = n;
            if (idx == stall_byte && nstall < stall_len) begin
               if (nstall == 0) held = byte_data;
               else if (byte_data !== held) nstall_err++;
               if (rd_en) nstall_err++;
               byte_ready = 1'b0;
               nstall++;
            end else begin
               if (idx < NBYTE) begin
                  rec_data[idx] = byte_data; rec_rf[idx] = row_first; rec_ri[idx] = row_idx;
               end
               idx++;
            end
         end else if (nstall > 0 && nstall < stall_len) begin
            nstall_err++;
         end
         if (done) begin ndone++; dc = n; end
      end
      nacc = idx;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (k == 1) begin prd = rd_en; padr = rd_addr; end
         if (done) ndone++;
      end
      pbusy = busy;
   endtask

   // Reset during a read burst, with a start in the reset cycle, then a fresh start
   task automatic reset_at(input int n_rst, input int addr_exp);
      @(negedge clk); start = 1'b1;
      @(posedge clk);
      for (int n = 1; n <= n_rst; n++) begin
         @(negedge clk);
         if (n == 1) start = 1'b0;
      end
      chk("pre_rst_rd_en", rd_en, 1);
      chk("pre_rst_rd_addr", rd_addr, addr_exp);
      rst = 1'b1; start = 1'b1;
      @(negedge clk);
      check_reset_outputs("mid_rst");
      rst = 1'b0; start = 1'b0;
      @(negedge clk);
      chk("rst_start_ignored", busy, 0);
      start = 1'b1;
      @(posedge clk);
      @(negedge clk); start = 1'b0;
      chk("restart_rd_en", rd_en, 1);
      chk("restart_addr0", rd_addr, 0);
      @(negedge clk);
      chk("restart_addr1", rd_addr, 1);
      do_reset();
   endtask

   initial begin
      // Reset state
      for (int a = 0; a < NPIX; a++) mem[a] = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst = 1'b0;

      // Single lit pixel at address 0
      mem[0] = 1'b1;
      scan_frame(-1, 0, 1'b0);
      chk("s1_first_valid_cycle", fv, 10);
      chk("s1_first_addr", fa, 0);
      chk("s1_byte0", rec_data[0], 8'h80);
      chk("s1_row_first0", rec_rf[0], 1);
      chk("s1_row_idx0", rec_ri[0], 0);
      chk("s1_byte1", rec_data[1], 8'h00);
      chk("s1_done_cycle", dc, 20481);
      chk("s1_bytes", nacc, NBYTE);
      chk("s1_done_pulses", ndone, 1);
      model_check("s1_model");
`ifdef LCD_SCAN_CONTINUOUS_EN
      chk("cont_rd_en_after_done", prd, 1);
      chk("cont_addr_after_done", padr, 0);
`else
      chk("s1_idle_rd_en", prd, 0);
      chk("s1_idle_busy", pbusy, 0);
`endif
      do_reset();

      // Alternating 1010 pattern
      for (int a = 0; a < NPIX; a++) mem[a] = ((a % 2) == 0);
      scan_frame(-1, 0, 1'b0);
      chk("s2_byte0", rec_data[0], 8'hAA);
      chk("s2_byte_last", rec_data[NBYTE-1], 8'hAA);
      chk("s2_rf16", rec_rf[16], 1);
      chk("s2_ri16", rec_ri[16], 1);
      chk("s2_rf17", rec_rf[17], 0);
      chk("s2_ri17", rec_ri[17], 1);
      chk("s2_rf32", rec_rf[32], 1);
      chk("s2_ri32", rec_ri[32], 2);
      chk("s2_ri_last", rec_ri[NBYTE-1], 127);
      chk("s2_done_cycle", dc, 20481);
      model_check("s2_model");
      do_reset();

      // Backpressure on byte 3 for 50 cycles, plus a start re-pulse while busy
      for (int a = 0; a < NPIX; a++) mem[a] = (((a * 5) % 7) < 3);
      scan_frame(3, 50, 1'b1);
      chk("s3_stall_cycles", nstall, 50);
      chk("s3_stall_stable", nstall_err, 0);
      chk("s3_byte3", rec_data[3], exp_byte(3));
      chk("s3_bytes", nacc, NBYTE);
      chk("s3_done_cycle", dc, 20531);
      chk("s3_done_pulses", ndone, 1);
      model_check("s3_model");
`ifndef LCD_SCAN_CONTINUOUS_EN
      chk("s3_idle_busy", pbusy, 0);
`endif
      do_reset();

      // Reset in the 4th rd_en cycle of the frame and of the third byte
      reset_at(4, 3);
      reset_at(24, 19);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/lcd_fb_scanner.md
LCD_FB_SCANNER -- requirements
Module: lcd_fb_scanner

Interface
REQ-001 Parameter FB_W, default 128, framebuffer width in pixels; SHALL be a multiple of 8.
REQ-002 Parameter FB_H, default 128, framebuffer height in pixels; FB_W*FB_H SHALL equal 2^ADDR_W.
REQ-003 Parameter ADDR_W, default 14, framebuffer read-address width.
REQ-004 clk  in  1  single clock; all logic on the rising edge.
REQ-005 rst  in  1  reset; synchronous, active-high.
REQ-006 start  in  1  request one frame scan; sampled only in IDLE.
REQ-007 busy  out  1  high whenever the state is not IDLE.
REQ-008 done  out  1  one-cycle pulse after the last byte of a frame is accepted.
REQ-009 rd_en  out  1  framebuffer read-port enable.
REQ-010 rd_addr  out  ADDR_W  framebuffer read address, row*FB_W+col.
REQ-011 rd_data  in  1  framebuffer pixel, registered; valid the cycle after rd_en.
REQ-012 byte_data  out  8  packed pixels, leftmost pixel in bit 7.
REQ-013 byte_valid  out  1  byte_data is valid.
REQ-014 byte_ready  in  1  downstream LCD serializer accepts byte_data.
REQ-015 row_first  out  1  current byte is the first byte of a row; qualified by byte_valid.
REQ-016 row_idx  out  7  row index of the current byte; qualified by byte_valid.

Function
REQ-017 FSM states: IDLE, READ, DRAIN, OUT, DONE.
REQ-018 IDLE->READ on start=1; start is ignored in every state other than IDLE.
REQ-019 READ: rd_en=1 for exactly 8 consecutive cycles, with rd_addr = byte_base+0..7 in order.
REQ-020 DRAIN: the scanner shifts in one rd_data bit per cycle, 1 cycle behind rd_en, until 8 bits are captured; it then enters OUT.
REQ-021 OUT: byte_valid=1; byte_data, row_first and row_idx SHALL stay stable until a cycle with byte_valid=1 and byte_ready=1.
REQ-022 On handshake, byte_base advances by 8; the next state is READ, or DONE when byte_base was FB_W*FB_H-8.
REQ-023 DONE: done=1 for one cycle, then IDLE.
REQ-024 Latency: byte_valid SHALL first rise in cycle 10 after the edge that samples start (cycle 0).
REQ-025 With byte_ready held high, bytes SHALL be produced every 10 cycles, and done SHALL pulse in cycle 20481 for the default geometry.
REQ-026 rd_en=0 outside READ; rd_addr holds its last value.
REQ-027 Address wrap: after the final address (2^ADDR_W-1), byte_base returns to 0 for the next frame.
REQ-028 A handshake SHALL never occur while byte_valid=0; byte_ready is don't-care outside OUT.
REQ-029 row_first=1 when byte_base mod FB_W = 0.

Reset
REQ-030 rst=1 in any state SHALL force IDLE on the next edge, including mid-burst or mid-handshake.
REQ-031 Reset values: busy=0, done=0, rd_en=0, rd_addr=0, byte_data=0, byte_valid=0, row_first=0, row_idx=0; byte_base=0 and bit count=0.
REQ-032 A start asserted in the same cycle as rst SHALL be ignored.

Configuration
REQ-033 Macro LCD_SCAN_CONTINUOUS_EN.
- Defined: DONE returns to READ with byte_base=0, so scanning repeats until rst, and done still pulses once per frame.
- Undefined: DONE returns to IDLE and each frame needs a new start.

Structure
REQ-034 Shared package lcd_fb_pkg SHALL hold FB_W/FB_H/ADDR_W defaults, BYTES_PER_ROW=FB_W/8, and the FSM state typedef.
REQ-035 One sub-module, lcd_fb_packer: 8-bit MSB-first shift register with 3-bit count and a full flag.

Verification
REQ-036 The bench SHALL cover the following scenarios:
- Framebuffer preloaded with addr[0]=1 (all other pixels 0), start pulse, ready=1 -> first byte 8'h80 at cycle 10 with row_first=1 and row_idx=0; done at cycle 20481.
- Alternating 1010 pattern, ready=1 -> every byte is 8'hAA; row_first=1 on bytes 0, 16, 32, ...; row_idx increments every 16 bytes.
- ready held 0 for 50 cycles on byte 3 -> byte_valid and byte_data stable for all 50 cycles, no rd_en pulses, and a single accept when ready rises.
- start re-pulsed while busy -> no effect; exactly one done pulse.
- rst asserted during the 4th rd_en cycle -> next cycle: all outputs at reset values; a fresh start restarts at rd_addr=0.
- With LCD_SCAN_CONTINUOUS_EN defined -> second frame begins at rd_addr=0 in the cycle after done, with no start.
